// File: rtl/mips_mem_pkg.sv
// Shared types for the multicycle MIPS memory responder: FSM encoding, op codes,
// error-cause bits and the parity helper used when MEM_PARITY_EN is defined.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    ACCESS = 2'b10,
    DONE   = 2'b11
  } mem_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } mem_op_t;

  // Error causes are one-hot bits so several can be reported at once.
  localparam int ERR_W = 3;
  localparam logic [ERR_W-1:0] ERR_NONE       = 3'b000;
  localparam logic [ERR_W-1:0] ERR_ILLEGAL_OP = 3'b001;
  localparam logic [ERR_W-1:0] ERR_MISALIGNED = 3'b010;
  localparam logic [ERR_W-1:0] ERR_RANGE      = 3'b100;

  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port synchronous word RAM; with MEM_PARITY_EN defined each word
// carries one extra parity bit alongside the data.
module mem_word_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          cclk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   din,
`ifdef MEM_PARITY_EN
  input  logic          din_par,
  output logic          dout_par,
`endif
  output logic [31:0]   dout
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge cclk) begin
    if (we) mem[idx] <= din;
    dout <= mem[idx];
  end

`ifdef MEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge cclk) begin
    if (we) par_mem[idx] <= din_par;
    dout_par <= par_mem[idx];
  end
`endif

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multicycle MIPS core: captures a strobe in IDLE,
// waits WAIT_CYCLES, accesses the word array, then pulses mem_ready. Optional MEM_PARITY_EN.
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        cclk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef MEM_PARITY_EN
  input  logic        inject_perr,
`endif
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        mem_err,
  output mem_state_t  dbg_state
);

  // Handshake: mem_read/mem_write are single-cycle requests accepted only in IDLE;
  // anything seen in WAIT/ACCESS/DONE is dropped. mem_ready is a one-cycle
  // completion pulse with no backpressure, mem_err qualifies that same cycle.

  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mem_state_t       state_q, state_d;
  logic [3:0]       cnt_q;
  logic [AW-1:0]    idx_q;
  logic [31:0]      wdata_q;
  mem_op_t          op_q;
  logic [ERR_W-1:0] cause_q, cap_cause;
  logic [31:0]      rhold_q, rdata_done;
  logic             capture, ram_we, perr;
  logic [31:0]      ram_dout;

  assign capture = (state_q == IDLE) && (mem_read || mem_write);

  always_comb begin
    cap_cause = ERR_NONE;
    if (mem_read && mem_write)          cap_cause = cap_cause | ERR_ILLEGAL_OP;
    if (addr[1:0] != 2'b00)             cap_cause = cap_cause | ERR_MISALIGNED;
    if ((addr >> (AW + 2)) != 32'd0)    cap_cause = cap_cause | ERR_RANGE;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          if (WAIT_CYCLES > 0) state_d = WAIT;
          else                 state_d = ACCESS;
        end
      end
      WAIT:    if (cnt_q == WAIT_LAST) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cclk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rhold_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == WAIT) cnt_q <= (cnt_q == WAIT_LAST) ? 4'd0 : cnt_q + 4'd1;
      if (state_q == DONE) rhold_q <= rdata_done;
    end
  end

  // Request registers are datapath only; they are always reloaded before use.
  always_ff @(posedge cclk) begin
    if (capture) begin
      idx_q   <= addr[AW+1:2];
      wdata_q <= wdata;
      cause_q <= cap_cause;
      if (mem_write) op_q <= OP_WR;
      else           op_q <= OP_RD;
    end
  end

  // Gating with rst makes a reset landing on ACCESS abort the write too.
  assign ram_we = (state_q == ACCESS) && (op_q == OP_WR) && (cause_q == ERR_NONE) && !rst;

`ifdef MEM_PARITY_EN
  logic ram_dout_par;

  mem_word_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .cclk     (cclk),
    .we       (ram_we),
    .idx      (idx_q),
    .din      (wdata_q),
    .din_par  (even_parity(wdata_q) ^ inject_perr),
    .dout_par (ram_dout_par),
    .dout     (ram_dout)
  );

  assign perr = (op_q == OP_RD) && (cause_q == ERR_NONE) &&
                (ram_dout_par != even_parity(ram_dout));
`else
  mem_word_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .cclk (cclk),
    .we   (ram_we),
    .idx  (idx_q),
    .din  (wdata_q),
    .dout (ram_dout)
  );

  assign perr = 1'b0;
`endif

  // Array dout is valid in DONE because the read was issued on the ACCESS edge.
  always_comb begin
    rdata_done = rhold_q;
    if (cause_q != ERR_NONE) rdata_done = 32'd0;
    else if (op_q == OP_RD)  rdata_done = ram_dout;
  end

  assign rdata     = (state_q == DONE) ? rdata_done : rhold_q;
  assign mem_ready = (state_q == DONE);
  assign mem_busy  = (state_q == WAIT) || (state_q == ACCESS);
  assign mem_err   = (state_q == DONE) && ((cause_q != ERR_NONE) || perr);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: a WAIT_CYCLES=2 instance and a zero-wait
// instance, a reference word model, and an expected queue of {err, rdata}.
`timescale 1ns/1ps
module tb_mips_mem_responder;
  import mips_mem_pkg::*;

  localparam int W  = 33;
  localparam int WC = 2;

  logic        cclk = 1'b0;
  logic        rst  = 1'b1;
  logic [31:0] addr = '0, wdata = '0;
  logic        rd_a = 1'b0, wr_a = 1'b0, rd_z = 1'b0, wr_z = 1'b0;
`ifdef MEM_PARITY_EN
  logic        inject_perr = 1'b0;
`endif
  logic [31:0] rdata_a, rdata_z;
  logic        ready_a, busy_a, err_a, ready_z, busy_z, err_z;
  mem_state_t  st_a, st_z;

  logic [W-1:0] exp_q[$];
  logic [31:0]  model [int];
  bit           par_bad [int];
  logic [31:0]  last_rd [2];
  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 cclk = ~cclk;

  mips_mem_responder #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(WC)) u_dut (
    .cclk(cclk), .rst(rst), .mem_read(rd_a), .mem_write(wr_a), .addr(addr), .wdata(wdata),
`ifdef MEM_PARITY_EN
    .inject_perr(inject_perr),
`endif
    .rdata(rdata_a), .mem_ready(ready_a), .mem_busy(busy_a), .mem_err(err_a), .dbg_state(st_a)
  );

  mips_mem_responder #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(0)) u_dut_zw (
    .cclk(cclk), .rst(rst), .mem_read(rd_z), .mem_write(wr_z), .addr(addr), .wdata(wdata),
`ifdef MEM_PARITY_EN
    .inject_perr(inject_perr),
`endif
    .rdata(rdata_z), .mem_ready(ready_z), .mem_busy(busy_z), .mem_err(err_z), .dbg_state(st_z)
  );

  // {ready, busy, err, rdata} of the selected instance
  function automatic logic [34:0] outs(input int which);
    if (which != 0) return {ready_z, busy_z, err_z, rdata_z};
    return {ready_a, busy_a, err_a, rdata_a};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_strobes(input int which, input logic rd, input logic wr);
    if (which != 0) begin rd_z = rd; wr_z = wr; end
    else            begin rd_a = rd; wr_a = wr; end
  endtask

  // Drives one request, pushes the model's {err, rdata}, waits for ready and compares.
  // disturb keeps both strobes high and scrambles addr/wdata through WAIT and DONE.
  task automatic do_req(input int which, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input bit perr_inj, input bit disturb, input string tag);
    int          wc;
    int          key;
    int          k;
    int          busy_n;
    int          stray;
    bit          seen;
    logic        e;
    logic [31:0] er;
    logic [34:0] o;
    logic [W-1:0] exp_v;
    wc  = (which != 0) ? 0 : WC;
    key = which * 4096 + int'(a[11:2]);
    e   = (rd && wr) || (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
    if (e) er = 32'd0;
    else if (wr) begin
      model[key]   = d;
      par_bad[key] = perr_inj;
      er = last_rd[which];
    end else begin
      er = model[key];
`ifdef MEM_PARITY_EN
      e = par_bad[key];
`endif
    end
    last_rd[which] = er;
    exp_q.push_back({e, er});

    @(negedge cclk);
    addr = a; wdata = d;
`ifdef MEM_PARITY_EN
    inject_perr = perr_inj;
`endif
    set_strobes(which, rd, wr);
    @(posedge cclk);
    @(negedge cclk);
    if (disturb) begin
      addr = ~a; wdata = ~d;
      set_strobes(which, 1'b1, 1'b1);
    end else set_strobes(which, 1'b0, 1'b0);

    k = 0; busy_n = 0; seen = 0;
    while (!seen && k < 40) begin
      o = outs(which);
      if (o[34]) seen = 1;
      else begin
        busy_n += int'(o[33]);
        @(posedge cclk);
        @(negedge cclk);
        k++;
      end
    end
    if (!seen) begin
      check({tag, "_timeout"}, 33'd0, 33'd1);
      void'(exp_q.pop_front());
    end else begin
      // ready seen k edges after capture edge N, i.e. in the cycle ending at edge N+k+1
      check({tag, "_latency"}, 33'(k), 33'(wc + 1));
      check({tag, "_busy_cycles"}, 33'(busy_n), 33'(wc + 1));
      exp_v = exp_q.pop_front();
      check({tag, "_resp"}, {o[32], o[31:0]}, exp_v);
      check({tag, "_busy_at_ready"}, 33'(o[33]), 33'd0);
      @(posedge cclk);
      @(negedge cclk);
      set_strobes(which, 1'b0, 1'b0);
`ifdef MEM_PARITY_EN
      inject_perr = 1'b0;
`endif
      o = outs(which);
      check({tag, "_held"}, {o[34], o[31:0]}, {1'b0, er});
      if (disturb) begin
        stray = 0;
        for (int i = 0; i < 2 * WC + 4; i++) begin
          @(negedge cclk);
          o = outs(which);
          stray += int'(o[34]) + int'(o[33]);
        end
        check({tag, "_no_extra_req"}, 33'(stray), 33'd0);
      end
    end
  endtask

  initial begin
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) @(posedge cclk);
    @(negedge cclk);
    rst = 1'b0;
    check("reset_a_rdata", {1'b0, rdata_a}, 33'd0);
    check("reset_a_flags", 33'({ready_a, busy_a, err_a, st_a}), 33'd0);
    check("reset_z_flags", 33'({ready_z, busy_z, err_z, st_z, rdata_z}), 33'd0);

    do_req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, "wr_10");
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, "rd_10");
    do_req(1, 1'b0, 1'b1, 32'h10, 32'h0BADCAFE, 1'b0, 1'b0, "zw_wr_10");
    do_req(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, "zw_rd_10");

    do_req(0, 1'b0, 1'b1, 32'h13, 32'h99999999, 1'b0, 1'b0, "wr_misaligned");
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, "rd_10_after_mis");
    do_req(0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0, "rd_misaligned");
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, "rd_10_restore");
    do_req(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 1'b0, "rd_range");
    do_req(0, 1'b1, 1'b1, 32'h10, 32'h12345678, 1'b0, 1'b0, "both_strobes");
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, "rd_10_disturbed");
    do_req(0, 1'b0, 1'b1, 32'hFFC, 32'hA5A5F00F, 1'b0, 1'b1, "wr_top_disturbed");
    do_req(0, 1'b1, 1'b0, 32'hFFC, 32'h0, 1'b0, 1'b0, "rd_top");

    for (int i = 0; i < 5; i++) begin
      logic [31:0] ra, rd;
      ra = {20'd0, 10'($urandom_range(64, 1023)), 2'b00};
      rd = $urandom;
      do_req(0, 1'b0, 1'b1, ra, rd, 1'b0, 1'b0, "rand_wr");
      do_req(0, 1'b1, 1'b0, ra, 32'h0, 1'b0, 1'b0, "rand_rd");
    end

    // reset while a write to 0x20 sits in WAIT
    do_req(0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0, 1'b0, "wr_20");
    do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, "rd_20");
    @(negedge cclk);
    addr = 32'h20; wdata = 32'h11111111; wr_a = 1'b1;
    @(posedge cclk);
    @(negedge cclk);
    wr_a = 1'b0;
    check("pre_reset_busy", 33'(busy_a), 33'd1);
    rst = 1'b1;
    @(posedge cclk);
    @(negedge cclk);
    rst = 1'b0;
    check("mid_reset_rdata", {1'b0, rdata_a}, 33'd0);
    check("mid_reset_flags", 33'({ready_a, busy_a, err_a, st_a}), 33'd0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (4) @(negedge cclk);
    check("post_reset_idle", 33'({ready_a, busy_a, err_a}), 33'd0);
    do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, "rd_20_after_reset");

`ifdef MEM_PARITY_EN
    do_req(0, 1'b0, 1'b1, 32'h40, 32'h55AA55AA, 1'b1, 1'b0, "wr_40_bad_par");
    do_req(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, "rd_40_bad_par");
    do_req(0, 1'b0, 1'b1, 32'h44, 32'h00000001, 1'b0, 1'b0, "wr_44");
    do_req(0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, "rd_44");
`endif

    check("queue_drained", 33'(exp_q.size()), 33'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Memory-side responder for the multicycle MIPS core.
- Accepts the one-cycle MemRead/MemWrite strobes that the control unit issues in fetch, load and store states, together with the datapath address and write data.
- Serves each request from an internal word array after a programmable number of wait states.
- Signals completion with a one-cycle ready pulse and holds read data stable until the next read completes.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of 2.
- AW, 10, word-index width = log2(DEPTH).
- WAIT_CYCLES, 2, wait states between request capture and access; range 0..15.

Ports:
- cclk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- mem_read  in  1  read strobe, sampled only in IDLE.
- mem_write  in  1  write strobe, sampled only in IDLE.
- addr  in  32  byte address from IorD mux.
- wdata  in  32  store data (register B).
- rdata  out  32  read data to IR/MDR.
- mem_ready  out  1  one-cycle completion pulse.
- mem_busy  out  1  high while a request is pending (WAIT or ACCESS).
- mem_err  out  1  one-cycle error pulse, coincident with mem_ready.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; rdata=0; mem_ready=0; mem_busy=0; mem_err=0; wait counter=0. Array contents are not cleared. Reset mid-request aborts it, and no array write occurs.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - If mem_read|mem_write, capture addr, wdata and op into registers.
  - Go to WAIT if WAIT_CYCLES>0, else to ACCESS.
  - Set mem_busy=1 from the next cycle.
- WAIT: counter counts 0..WAIT_CYCLES-1, then go to ACCESS. Strobe inputs are ignored, and strobe deassertion does not cancel the request.
- ACCESS:
  - Perform the array operation using captured values only.
  - Read: rdata <= array[addr_q[AW+1:2]].
  - Write: array[...] <= wdata_q; rdata is unchanged.
  - Go to DONE.
- DONE: mem_ready=1 and mem_busy=0 for exactly this cycle; next state is IDLE.
- Strobes present in DONE are not captured; a requester must re-strobe in IDLE.
- Latency: strobe at edge N gives mem_ready high during cycle N+WAIT_CYCLES+2.
- Errors: the request still completes with ready, but there is no array write and rdata is forced to 0. Error conditions:
  - mem_read & mem_write both high at capture (illegal op);
  - addr_q[1:0] != 0 (misaligned);
  - addr_q[31:AW+2] != 0 (out of range).
- rdata holds its value between reads, including across writes and error-free idle periods.

Optional Feature:
- Macro: MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed on write.
  - On read, a parity mismatch raises mem_err; rdata still returns the stored data.
  - Adds input inject_perr (1 bit), which, when high at the write ACCESS cycle, stores inverted parity.
- Undefined: no parity storage, no inject_perr port, and mem_err comes from address/op errors only.

Decomposition:
- Package mips_mem_pkg:
  - state encoding localparams (IDLE=2'b00, WAIT=2'b01, ACCESS=2'b10, DONE=2'b11);
  - op codes (OP_RD, OP_WR);
  - error-cause constants for the bench.
- Sub-module mem_word_array: single-port synchronous RAM with we, idx[AW-1:0], din, dout, plus a parity bit column under MEM_PARITY_EN.
- The FSM, counter and error checks stay in the top module.

Test Plan:
- Write then read, WAIT_CYCLES=2:
  - write addr=0x10, wdata=0xDEADBEEF → ready at cycle 4, err=0;
  - read 0x10 → rdata=0xDEADBEEF on the ready cycle and held after.
- Zero-wait build (WAIT_CYCLES=0): read strobe at edge N → ready during N+2 and busy high for exactly 1 cycle.
- Misaligned write addr=0x13 → ready+err together; a subsequent read of 0x10 still returns the old value; a read of 0x13 returns rdata=0.
- Out of range: read addr=0x0000_1000 with DEPTH=1024 → err=1, rdata=0.
- Both strobes high → err=1, no write.
- Strobes asserted during WAIT and DONE → ignored; exactly one ready per IDLE capture.
- Reset at the WAIT cycle of a write to 0x20 → all outputs 0 next cycle, and a later read of 0x20 returns its prior contents.
- MEM_PARITY_EN: write 0x55AA55AA to 0x40 with inject_perr=1 → read 0x40 gives rdata=0x55AA55AA and err=1.
